// File: rtl/mips_dbridge_defs.sv
// rtl/mips_dbridge_defs.sv - shared MMIO offsets, STATUS bit positions and default page base
package mips_dbridge_defs;

  typedef enum logic [1:0] {
    OFF_TX_DATA = 2'd0,
    OFF_STATUS  = 2'd1,
    OFF_LED     = 2'd2,
    OFF_CYCLE   = 2'd3
  } mmio_off_e;

  localparam int STATUS_EMPTY = 0;
  localparam int STATUS_FULL  = 1;
  localparam int STATUS_OVF   = 2;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

endpackage

// File: rtl/dbridge_fifo.sv
// rtl/dbridge_fifo.sv - synchronous FIFO; a push while full is only taken when a pop frees a slot
module dbridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_data_bridge.sv
// rtl/mips_data_bridge.sv - CPU data-port RAM plus MMIO page (TX FIFO, LED, STATUS, CYCLE)
// CYCLE counter present only when MIPS_DBRIDGE_CYCLE_CNT_EN is defined.
module mips_data_bridge
  import mips_dbridge_defs::*;
#(
  parameter int          RAM_AW    = 10,
  parameter int          TX_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        mem_read_en,
  input  logic [3:0]  mem_write_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [7:0]  led
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [3:0][7:0] ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic        mmio_sel, reg_hit, wr_any;
  mmio_off_e   off;
  logic        push, pop, ovf, ovf_set, ovf_clr;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic [CW-1:0] fifo_count;
  logic [31:0] status_word, cycle_val, mmio_rdata;
  logic        unused_bits;

  assign mmio_sel = (mem_addr[31:16] == MMIO_BASE[31:16]);
  assign reg_hit  = mmio_sel & (mem_addr[15:4] == '0);
  assign off      = mmio_off_e'(mem_addr[3:2]);
  assign wr_any   = |mem_write_en;
  assign ram_idx  = mem_addr[RAM_AW+1:2];
  assign unused_bits = ^{mem_addr[1:0], fifo_count};

  assign tx_valid = ~fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_head;
  assign push     = en & reg_hit & (off == OFF_TX_DATA) & wr_any;
  assign pop      = en & tx_valid & tx_ready;
  assign ovf_set  = push & fifo_full & ~pop;
  assign ovf_clr  = en & reg_hit & (off == OFF_STATUS) & wr_any & mem_write_data[STATUS_OVF];

  dbridge_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (mem_write_data[7:0]),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef MIPS_DBRIDGE_CYCLE_CNT_EN
  logic [31:0] cycle;
  always_ff @(posedge clk) begin
    if (rst)     cycle <= '0;
    else if (en) cycle <= cycle + 32'd1;
  end
  assign cycle_val = cycle;
`else
  assign cycle_val = '0;
`endif

  always_comb begin
    status_word               = '0;
    status_word[STATUS_EMPTY] = fifo_empty;
    status_word[STATUS_FULL]  = fifo_full;
    status_word[STATUS_OVF]   = ovf;
    mmio_rdata                = '0;
    if (reg_hit) begin
      case (off)
        OFF_STATUS: mmio_rdata = status_word;
        OFF_LED:    mmio_rdata = {24'b0, led};
        OFF_CYCLE:  mmio_rdata = cycle_val;
        default:    mmio_rdata = '0;
      endcase
    end
  end

  // Byte lane i of the word holds mem_write_data[8i+7:8i]; lane 3 is byte address 0.
  always_ff @(posedge clk) begin
    if (en & ~rst & ~mmio_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_write_en[i]) ram[ram_idx][i] <= mem_write_data[8*i +: 8];
      end
    end
  end

  // Reads sample state before this edge's updates, so set/clear lands one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read_data <= '0;
      led           <= '0;
      ovf           <= 1'b0;
    end else if (en) begin
      if (mem_read_en) mem_read_data <= mmio_sel ? mmio_rdata : ram[ram_idx];
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (reg_hit && off == OFF_LED && mem_write_en[0]) led <= mem_write_data[7:0];
    end
  end

endmodule

// File: tb/tb_mips_data_bridge.sv
// tb/tb_mips_data_bridge.sv - directed stimulus checked against a queue/array model every cycle
module tb_mips_data_bridge;

  localparam int RAM_AW    = 10;
  localparam int RAM_WORDS = 1 << RAM_AW;
  localparam int TXD       = 8;
  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_ST  = 32'hFFFF_0004;
  localparam logic [31:0] A_LED = 32'hFFFF_0008;
  localparam logic [31:0] A_CYC = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        mem_read_en = 1'b0;
  logic [3:0]  mem_write_en = 4'h0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic [7:0]  led;

  int checks = 0;
  int failures = 0;
  bit check_on = 0;

  mips_data_bridge #(.RAM_AW(RAM_AW), .TX_DEPTH(TXD)) dut (
    .clk(clk), .rst(rst), .en(en), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state
  logic [31:0] ram_m [RAM_WORDS];
  bit          ram_k [RAM_WORDS];
  logic [7:0]  q [$];
  logic [31:0] exp_rd;
  bit          rd_known = 0;
  bit          m_ovf;
  logic [7:0]  m_led;
  logic [31:0] m_cyc;
  bit          m_mm, m_inr, m_pop, m_push, m_set, m_clr;
  int          m_off;
  int unsigned m_idx;

  always @(posedge clk) begin
    if (rst) begin
      exp_rd = '0; rd_known = 1; q.delete(); m_ovf = 0; m_led = '0; m_cyc = '0;
    end else if (en) begin
      m_mm  = (mem_addr[31:16] == 16'hFFFF);
      m_inr = m_mm && (mem_addr[15:0] < 16'd16);
      m_off = int'(mem_addr[15:0]) / 4;
      m_idx = (mem_addr / 4) % RAM_WORDS;
      if (mem_read_en) begin
        if (m_mm) begin
          rd_known = 1;
          exp_rd = '0;
          if (m_inr) begin
            case (m_off)
              1: exp_rd = {29'b0, m_ovf, (q.size() == TXD), (q.size() == 0)};
              2: exp_rd = {24'b0, m_led};
`ifdef MIPS_DBRIDGE_CYCLE_CNT_EN
              3: exp_rd = m_cyc;
`endif
              default: exp_rd = '0;
            endcase
          end
        end else begin
          exp_rd = ram_m[m_idx];
          rd_known = ram_k[m_idx];
        end
      end
      m_pop  = (q.size() != 0) && tx_ready;
      m_push = m_inr && m_off == 0 && mem_write_en != 0;
      m_set  = m_push && q.size() == TXD && !m_pop;
      m_clr  = m_inr && m_off == 1 && mem_write_en != 0 && mem_write_data[2];
      if (m_pop) void'(q.pop_front());
      if (m_push && !m_set) q.push_back(mem_write_data[7:0]);
      if (m_set) m_ovf = 1;
      else if (m_clr) m_ovf = 0;
      if (m_inr && m_off == 2 && mem_write_en[0]) m_led = mem_write_data[7:0];
      if (!m_mm) begin
        for (int b = 0; b < 4; b++)
          if (mem_write_en[b]) ram_m[m_idx][8*b +: 8] = mem_write_data[8*b +: 8];
        if (mem_write_en == 4'hF) ram_k[m_idx] = 1;
      end
      m_cyc = m_cyc + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, q.size() != 0});
      chk("tx_data", {24'b0, tx_data}, {24'b0, (q.size() != 0) ? q[0] : 8'h00});
      chk("led", {24'b0, led}, {24'b0, m_led});
      if (rd_known) chk("mem_read_data", mem_read_data, exp_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] wd);
    mem_read_en = rd; mem_write_en = we; mem_addr = a; mem_write_data = wd;
    tick();
    mem_read_en = 0; mem_write_en = 4'h0;
  endtask

  logic [31:0] v1, v2;
  logic [7:0]  drain_exp [TXD];

  initial begin
    tick(); tick();
    rst = 0;
    check_on = 1;
    chk("reset_rd", mem_read_data, 32'h0);
    chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("reset_led", {24'b0, led}, 32'h0);

    // RAM byte lanes
    drive(0, 4'hF, 32'h10, 32'h1122_3344);
    drive(0, 4'b0010, 32'h12, 32'hAAAA_AAAA);
    drive(1, 4'h0, 32'h10, 32'h0);
    chk("lw_lanes", mem_read_data, 32'h1122_AA44);

    // Aliasing
    drive(0, 4'hF, 32'h0, 32'hDEAD_BEEF);
    drive(1, 4'h0, 32'(4 << RAM_AW), 32'h0);
    chk("alias", mem_read_data, 32'hDEAD_BEEF);

    // FIFO fill and overflow
    tx_ready = 0;
    for (int i = 1; i <= 8; i++) drive(0, 4'hF, A_TX, 32'(i));
    drive(1, 4'h0, A_ST, 32'h0);
    chk("status_full", mem_read_data, 32'h2);
    drive(0, 4'hF, A_TX, 32'h9);
    drive(1, 4'h0, A_ST, 32'h0);
    chk("status_ovf", mem_read_data, 32'h6);
    tx_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_byte", {24'b0, tx_data}, 32'(i));
      tick();
    end
    chk("drain_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 0;
    drive(0, 4'hF, A_ST, 32'h4);
    drive(1, 4'h0, A_ST, 32'h0);
    chk("ovf_cleared", mem_read_data, 32'h1);

    // Full push + pop in one cycle
    for (int i = 0; i < 8; i++) drive(0, 4'hF, A_TX, 32'h11 + 32'(i));
    tx_ready = 1;
    drive(0, 4'hF, A_TX, 32'h55);
    tx_ready = 0;
    drive(1, 4'h0, A_ST, 32'h0);
    chk("full_pushpop_status", mem_read_data, 32'h2);
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'h12 + 8'(i);
    drain_exp[7] = 8'h55;
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("pushpop_byte", {24'b0, tx_data}, {24'b0, drain_exp[i]});
      tick();
    end
    tx_ready = 0;

    // LED and out-of-range page offsets
    drive(0, 4'b0001, A_LED, 32'h0000_00A5);
    drive(0, 4'b1110, A_LED, 32'h0000_003C);
    drive(0, 4'hF, 32'hFFFF_0018, 32'h0000_0011);
    drive(1, 4'h0, A_LED, 32'h0);
    chk("led_read", mem_read_data, 32'h0000_00A5);
    drive(1, 4'h0, 32'hFFFF_0010, 32'h0);
    chk("page_hole", mem_read_data, 32'h0);

    // en gating
    drive(0, 4'hF, 32'h20, 32'h1234_5678);
    drive(1, 4'h0, 32'h10, 32'h0);
    en = 0;
    drive(0, 4'hF, 32'h20, 32'hCAFE_F00D);
    drive(0, 4'hF, A_TX, 32'h77);
    drive(1, 4'h0, 32'h20, 32'h0);
    chk("en0_hold", mem_read_data, 32'h1122_AA44);
    en = 1;
    drive(1, 4'h0, 32'h20, 32'h0);
    chk("en0_no_write", mem_read_data, 32'h1234_5678);
    chk("en0_no_push", {31'b0, tx_valid}, 32'h0);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) drive(0, 4'hF, A_TX, 32'hA0 + 32'(i));
    tx_ready = 1;
    tick();
    rst = 1;
    tick();
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_led", {24'b0, led}, 32'h0);
    rst = 0;
    tx_ready = 0;

    // Cycle counter
    drive(1, 4'h0, A_CYC, 32'h0);
    v1 = mem_read_data;
    for (int i = 0; i < 9; i++) tick();
    drive(1, 4'h0, A_CYC, 32'h0);
    v2 = mem_read_data;
`ifdef MIPS_DBRIDGE_CYCLE_CNT_EN
    chk("cycle_delta", v2 - v1, 32'd10);
`else
    chk("cycle_zero_a", v1, 32'h0);
    chk("cycle_zero_b", v2, 32'h0);
`endif

    tick();
    check_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_data_bridge.md
Name: mips_data_bridge

Overview:
- Data-side memory subsystem directly downstream of the MIPS CPU's M-stage data port.
- Consumes mem_read_en / mem_write_en / mem_addr / mem_write_data, and returns mem_read_data exactly one cycle after the request, matching the CPU's X-issue / M-consume timing.
- Contains a word-addressed synchronous data RAM and a small MMIO register page: TX byte FIFO with valid/ready drain, LED register, status register and optional cycle counter.

Parameters:
- RAM_AW, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB).
- TX_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- MMIO_BASE, 32'hFFFF_0000, base of the MMIO page; the page is selected when mem_addr[31:16] == MMIO_BASE[31:16].

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- en  in  1  global enable, the same signal the CPU receives.
- mem_read_en  in  1  read request, X stage.
- mem_write_en  in  4  byte-lane write enables; bit3 = data[31:24] = byte address 0 (big-endian).
- mem_addr  in  32  byte address.
- mem_write_data  in  32  write data, already lane-replicated by the CPU.
- mem_read_data  out  32  registered read data, valid the cycle after mem_read_en.
- tx_valid  out  1  FIFO head valid.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  consumer accepts head.
- led  out  8  LED register.

Interface: one clock; reset is synchronous and active-high (ports named clk and rst).

Behaviour:
- Reset (rst=1 at a clk edge): mem_read_data=0, tx_valid=0, tx_data=0, led=0, FIFO count=0, overflow=0, cycle=0. RAM contents are not reset. rst overrides en.
- en=0: no RAM writes, no FIFO push/pop, no register updates, mem_read_data holds. The cycle counter also freezes.
- Decode, on mem_addr:
  - MMIO if mem_addr[31:16]==MMIO_BASE[31:16].
  - Otherwise RAM, index mem_addr[RAM_AW+1:2]. Upper bits are ignored, so the RAM aliases/wraps.
- RAM:
  - Write: per-lane byte write on mem_write_en.
  - Read: registered, latency 1.
  - Simultaneous read and write to the same word in one cycle is illegal from the CPU. If it occurs, read returns old data.
- MMIO offsets (mem_addr[3:2]):
  - 0 TX_DATA. Any nonzero mem_write_en pushes mem_write_data[7:0]. Reads return 0.
  - 1 STATUS. Read: {29'b0, overflow, full, empty}. Write with mem_write_data[2]=1 clears overflow.
  - 2 LED. Write loads led from mem_write_data[7:0] when mem_write_en[0]=1. Read returns {24'b0, led}.
  - 3 CYCLE. Read returns the counter value (see Optional Feature). Writes are ignored.
  - Offsets outside 0x0-0xF within the page read 0 and ignore writes.
- MMIO reads: return the state before the same edge's updates. A read in the cycle after a write sees the new value.
- FIFO:
  - Pop when tx_valid & tx_ready & en.
  - tx_valid = count!=0; tx_data = head when valid, else 0.
  - Push when full and no pop in the same cycle: byte dropped, overflow set (sticky).
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push when empty: no same-cycle pop (tx_valid=0); tx_valid rises next cycle.
  - Pointers wrap modulo TX_DEPTH. Count width is log2(TX_DEPTH)+1.
  - Overflow set and clear in the same cycle: set wins.
- mem_read_en=0: mem_read_data holds its last value.

Optional Feature:
- Macro: MIPS_DBRIDGE_CYCLE_CNT_EN.
- Defined: 32-bit free-running counter, +1 every clk with en=1, wraps 0xFFFFFFFF→0, reset to 0; readable at CYCLE.
- Undefined: no counter flops; CYCLE reads 0.

Decomposition:
- Shared package/header mips_dbridge_defs:
  - MMIO offset constants (TX_DATA=0, STATUS=1, LED=2, CYCLE=3).
  - STATUS bit positions (EMPTY=0, FULL=1, OVF=2).
  - Default MMIO_BASE.
- Sub-module dbridge_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised width and depth.
- RAM stays inline as a byte-lane array.

Test Plan:
- RAM lanes: sw 0x11223344 @0x10; sb 0xAA @0x12 (lanes = 4'b0010, data replicated); lw @0x10 → 0x1122AA44 one cycle after the request.
- Aliasing: sw 0xDEADBEEF @0x0; lw @(4<<RAM_AW) → 0xDEADBEEF.
- FIFO fill and overflow (tx_ready=0): push 9 bytes 0x01..0x09 → STATUS=3'b010 after 8; after the 9th, STATUS=3'b110. Drain with tx_ready=1 → tx_data 0x01..0x08 on consecutive cycles, then tx_valid=0. Write 4 to STATUS → overflow=0.
- Full push+pop: FIFO full, tx_ready=1, push 0x55 in the same cycle → count stays 8, overflow=0, 0x55 emerges last.
- en gating: en=0 with sw @0x20 and TX push → RAM word and FIFO unchanged, mem_read_data held. rst asserted mid-drain → tx_valid=0, led=0 next cycle.
- Cycle counter: with MIPS_DBRIDGE_CYCLE_CNT_EN, two CYCLE reads 10 enabled cycles apart differ by 10. Without the macro, CYCLE reads return 0.
